// File: rtl/conv_output_collector_if.sv
// Result stream from the convolution output collector to its consumer.
// The master drives valid/data; the slave drives ready.
interface conv_output_collector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/conv_output_collector.sv
// Keeps valid-window convolution results, optionally applies ReLU, and
// queues them in a small registered FIFO with stall and overflow flags.
module conv_output_collector #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_SIZE     = 3,
    parameter int RELU       = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] conv_i,
    output logic                  stall_o,
    output logic                  frame_done,
    output logic                  overflow,
    conv_output_collector_if.master out_if
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] KM1  = CW'(K_SIZE - 1);
    localparam logic [AW:0]   DEPTH  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ALMOST = (AW + 1)'(FIFO_DEPTH - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          en_d_q;
    logic          wv_q, wv_d;
    logic          last_q, last_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] wdata;
    logic wr, pop, full, push;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        wv_d   = en && (row_q >= KM1) && (col_q >= KM1);
        last_d = en && (row_q == LAST) && (col_q == LAST);
        if (en) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // conv_i carries the result for the pixel accepted one cycle earlier
    assign wr    = en_d_q & wv_q;
    assign pop   = out_if.out_valid & out_if.out_ready;
    assign full  = (cnt_q == DEPTH);
    assign push  = wr & (~full | pop);
    assign wdata = ((RELU != 0) && conv_i[DATA_WIDTH-1]) ? '0 : conv_i;

    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d  = ovf_q | (wr & full & ~pop);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            en_d_q <= 1'b0;
            wv_q   <= 1'b0;
            last_q <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            en_d_q <= en;
            wv_q   <= wv_d;
            last_q <= last_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign out_if.out_valid = (cnt_q != '0);
    assign out_if.out_data  = out_if.out_valid ? mem_q[rptr_q] : '0;
    assign stall_o          = (cnt_q >= ALMOST);
    assign frame_done       = wr & last_q;
    assign overflow         = ovf_q;
endmodule

// File: tb/tb_conv_output_collector.sv
// Bench for conv_output_collector: RELU=0 and RELU=1 instances share one
// stimulus stream; a cycle model feeds per-instance expected-result queues.
module tb_conv_output_collector;
    localparam int N = 4;
    localparam int K = 3;
    localparam int D = 4;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] v;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] conv_i = '0;
    logic         rdy = 1'b0;
    logic         stall0, stall1, fd0, fd1, ovf0, ovf1;

    conv_output_collector_if #(.DATA_WIDTH(W)) if0 ();
    conv_output_collector_if #(.DATA_WIDTH(W)) if1 ();

    assign if0.out_ready = rdy;
    assign if1.out_ready = rdy;

    conv_output_collector #(
        .N(N), .DATA_WIDTH(W), .K_SIZE(K), .RELU(0), .FIFO_DEPTH(D)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .conv_i(conv_i),
        .stall_o(stall0), .frame_done(fd0), .overflow(ovf0),
        .out_if(if0)
    );

    conv_output_collector #(
        .N(N), .DATA_WIDTH(W), .K_SIZE(K), .RELU(1), .FIFO_DEPTH(D)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .conv_i(conv_i),
        .stall_o(stall1), .frame_done(fd1), .overflow(ovf1),
        .out_if(if1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int row = 0, col = 0, occ = 0, fd_m = 0;
    bit ovf_m = 0;
    bit p_en = 0, p_wv = 0, p_last = 0;
    logic [W-1:0] p_v = '0, p_e0 = '0, p_e1 = '0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int outs0 = 0, outs1 = 0, fds0 = 0, fds1 = 0;

    logic         pv0 = 0, pv1 = 0, prdy = 0;
    logic [W-1:0] pd0 = '0, pd1 = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock cycle: drive, check flags, advance the model
    task automatic cyc(input bit e, input logic [W-1:0] v,
                       input logic [W-1:0] e0, input logic [W-1:0] e1);
        bit wr, pp, fdx, st, ov;
        en     = e;
        conv_i = p_en ? p_v : W'($urandom);
        wr  = p_en && p_wv;
        pp  = rdy && (occ > 0);
        fdx = wr && p_last;
        st  = (occ >= D - 1);
        ov  = ovf_m;
        @(negedge clk);
        chk("stall0", 32'(stall0), 32'(st));
        chk("stall1", 32'(stall1), 32'(st));
        chk("overflow0", 32'(ovf0), 32'(ov));
        chk("overflow1", 32'(ovf1), 32'(ov));
        chk("frame_done0", 32'(fd0), 32'(fdx));
        chk("frame_done1", 32'(fd1), 32'(fdx));
        if (wr) begin
            if (occ == D && !pp) begin
                ovf_m = 1;
            end else begin
                q0.push_back(p_e0);
                q1.push_back(p_e1);
                occ++;
            end
        end
        if (pp) occ--;
        if (fdx) fd_m++;
        if (e) begin
            p_wv   = (row >= K - 1) && (col >= K - 1);
            p_last = (row == N - 1) && (col == N - 1);
            if (col == N - 1) begin
                col = 0;
                row = (row == N - 1) ? 0 : row + 1;
            end else begin
                col++;
            end
        end
        p_en = e;
        p_v  = v;
        p_e0 = e0;
        p_e1 = e1;
        @(posedge clk);
        #1;
    endtask

    task automatic px(input bit e, input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v[W-1] ? '0 : v;
        cyc(e, v, v, r);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("rst_valid0", 32'(if0.out_valid), 0);
        chk("rst_valid1", 32'(if1.out_valid), 0);
        chk("rst_data0", 32'(if0.out_data), 0);
        chk("rst_data1", 32'(if1.out_data), 0);
        chk("rst_fd0", 32'(fd0), 0);
        chk("rst_fd1", 32'(fd1), 0);
        chk("rst_ovf0", 32'(ovf0), 0);
        chk("rst_ovf1", 32'(ovf1), 0);
        chk("rst_stall0", 32'(stall0), 0);
        chk("rst_stall1", 32'(stall1), 0);
        row = 0; col = 0; occ = 0; ovf_m = 0;
        p_en = 0; p_wv = 0; p_last = 0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // pops, order and hold-while-stalled checks
    always @(negedge clk) begin
        if (rst) begin
            if (fd0) fds0++;
            if (fd1) fds1++;
            if (pv0 && !prdy)
                chk("hold0", {if0.out_valid, if0.out_data}, {1'b1, pd0});
            if (pv1 && !prdy)
                chk("hold1", {if1.out_valid, if1.out_data}, {1'b1, pd1});
            if (if0.out_valid && if0.out_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL extra0: got %0h expected none",
                             if0.out_data);
                end else begin
                    checks--;
                    chk("data0", 32'(if0.out_data), 32'(q0.pop_front()));
                    outs0++;
                end
            end
            if (if1.out_valid && if1.out_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL extra1: got %0h expected none",
                             if1.out_data);
                end else begin
                    checks--;
                    chk("data1", 32'(if1.out_data), 32'(q1.pop_front()));
                    outs1++;
                end
            end
            pv0  = if0.out_valid;
            pv1  = if1.out_valid;
            pd0  = if0.out_data;
            pd1  = if1.out_data;
            prdy = rdy;
        end else begin
            pv0 = 0;
            pv1 = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int o0, o1, f0, k;
        tbl = '{
            '{16'hFFFB, 16'hFFFB, 16'h0000},
            '{16'h0007, 16'h0007, 16'h0007},
            '{16'h8000, 16'h8000, 16'h0000},
            '{16'h0000, 16'h0000, 16'h0000},
            '{16'h7FFF, 16'h7FFF, 16'h7FFF},
            '{16'hFFFF, 16'hFFFF, 16'h0000},
            '{16'h0001, 16'h0001, 16'h0001},
            '{16'h1234, 16'h1234, 16'h1234}
        };

        #2;
        chk("init_valid0", 32'(if0.out_valid), 0);
        chk("init_data0", 32'(if0.out_data), 0);
        chk("init_ovf0", 32'(ovf0), 0);
        chk("init_stall1", 32'(stall1), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // full frame, index+1 results, free-flowing consumer
        rdy = 1'b1;
        o0 = outs0; f0 = fds0;
        for (int p = 0; p < N * N; p++) px(1'b1, W'(p + 1));
        repeat (4) px(1'b0, '0);
        chk("frame1_outs", 32'(outs0 - o0), 4);
        chk("frame1_fd", 32'(fds0 - f0), 1);
        chk("frame1_empty", 32'(q0.size()), 0);

        // two frames with gaps and random backpressure, table values
        o0 = outs0; o1 = outs1; f0 = fds0; k = 0;
        for (int p = 0; p < 2 * N * N; p++) begin
            int g = 0;
            while ((stall0 || $urandom_range(0, 3) == 0) && g < 20) begin
                rdy = ($urandom_range(0, 3) != 0);
                px(1'b0, W'($urandom));
                g++;
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (((p % 16) / 4 >= K - 1) && ((p % 4) >= K - 1)) begin
                cyc(1'b1, tbl[k].v, tbl[k].e0, tbl[k].e1);
                k++;
            end else begin
                px(1'b1, W'($urandom));
            end
        end
        rdy = 1'b1;
        repeat (8) px(1'b0, '0);
        chk("b2b_outs0", 32'(outs0 - o0), 8);
        chk("b2b_outs1", 32'(outs1 - o1), 8);
        chk("b2b_fd", 32'(fds0 - f0), 2);

        // consumer stalled: fill, swap on full, then drop
        rdy = 1'b0;
        for (int p = 0; p < N * N; p++) px(1'b1, W'(16'h0100 + p));
        for (int p = 0; p <= 10; p++) px(1'b1, W'(16'h0200 + p));
        chk("full_stall", 32'(stall0), 1);
        chk("full_no_ovf", 32'(ovf0), 0);
        rdy = 1'b1;
        px(1'b1, 16'h020B);
        rdy = 1'b0;
        chk("swap_no_ovf", 32'(ovf0), 0);
        chk("swap_stall", 32'(stall0), 1);
        px(1'b1, 16'h020C);
        chk("drop_ovf0", 32'(ovf0), 1);
        chk("drop_ovf1", 32'(ovf1), 1);
        for (int p = 13; p < N * N; p++) px(1'b1, W'(16'h0200 + p));
        rdy = 1'b1;
        repeat (6) px(1'b0, '0);
        chk("drain_empty", 32'(q0.size()), 0);
        chk("sticky_ovf", 32'(ovf0), 1);

        // reset mid-frame, then a fresh frame
        for (int p = 0; p < 9; p++) px(1'b1, W'($urandom));
        do_reset();
        o0 = outs0; f0 = fds0;
        for (int p = 0; p < N * N; p++) px(1'b1, W'(16'h0300 + p));
        repeat (4) px(1'b0, '0);
        chk("post_rst_outs", 32'(outs0 - o0), 4);
        chk("post_rst_fd", 32'(fds0 - f0), 1);
        chk("post_rst_ovf", 32'(ovf0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_output_collector.md
CONV_OUTPUT_COLLECTOR -- requirements
Module: conv_output_collector

Interface
REQ-001 SHALL have parameter N, default 4, meaning image width and height in pixels.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning fixed-point sample width (two's complement).
REQ-003 SHALL have parameter K_SIZE, default 3, meaning convolution kernel edge; legal range 1..N.
REQ-004 SHALL have parameter RELU, default 1, meaning 1 clamps negative results to zero and 0 passes results through.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries; power of two, at least 2.
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, meaning asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1 bit, meaning one raster-order input pixel is accepted by the upstream convolver this cycle.
REQ-009 SHALL have port conv_i, input, DATA_WIDTH bits, meaning the convolver accumulator output.
REQ-010 SHALL have port stall_o, output, 1 bit, meaning upstream deasserts en while high.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning out_data holds a valid result.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts out_data when out_valid is also high.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits, meaning a valid convolution result in raster order.
REQ-014 SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse when the last valid result of a frame is written to the FIFO.
REQ-015 SHALL have port overflow, output, 1 bit, meaning a sticky flag that a valid result was dropped.

Function
REQ-016 SHALL keep column counter col and row counter row, each 0..N-1.
- Both counters advance only on cycles with en high.
- col wraps from N-1 to 0 and increments row at that point.
- row wraps from N-1 to 0, which starts a new frame.
REQ-017 SHALL, on each en cycle, register a window-valid flag wv = (row >= K_SIZE-1) and (col >= K_SIZE-1), using the pre-increment counter values, together with a delayed enable en_d.
REQ-018 SHALL sample conv_i in the cycle after the en cycle (en_d high); the sampled value is the result whose window ends at the pixel accepted by that en.
REQ-019 SHALL write the sample to the FIFO only when both en_d and wv are high; all other samples are discarded.
REQ-020 SHALL write max(conv_i, 0) when RELU=1, comparing on the sign bit, and conv_i unchanged when RELU=0; no width change or rounding.
REQ-021 SHALL write exactly (N-K_SIZE+1)^2 results per N*N accepted pixels.
REQ-022 SHALL pulse frame_done for one cycle, in the write cycle of the result whose window ends at row=N-1, col=N-1.
REQ-023 SHALL implement the FIFO with registered storage, no fall-through: a write to an empty FIFO is first visible on out_data one cycle later.
REQ-024 SHALL pop when out_valid and out_ready are both high; out_data and out_valid SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 SHALL, on a simultaneous write and pop, perform both, including when the FIFO is full; occupancy is unchanged and overflow is not set.
REQ-026 SHALL, on a write to a full FIFO without a pop, drop the write and set overflow, which stays high until reset.
- When this happens the counters and frame_done still proceed.
REQ-027 SHALL drive stall_o = (occupancy >= FIFO_DEPTH-1), as a registered or combinational function of occupancy only.
REQ-028 SHALL ignore conv_i whenever en_d is low.

Reset
REQ-029 SHALL, while rst is low, immediately force:
- col, row, en_d, wv and FIFO pointers to 0;
- out_valid, frame_done, overflow and stall_o to 0;
- out_data to 0.
REQ-030 SHALL, when reset is asserted mid-frame, discard the FIFO contents and the partial frame; the first en after release is taken as pixel (0,0).

Verification
REQ-031 SHALL pass this scenario: N=4, K=3, RELU=0, out_ready=1, 16 consecutive en pulses with conv_i = pixel index + 1 presented the cycle after each en.
- Exactly 4 outputs: 11, 12, 15, 16.
- frame_done pulses once, with the 16 write.
REQ-032 SHALL pass this scenario: RELU=1, results -5, 7, -32768, 0 on the valid window positions.
- Outputs 0, 7, 0, 0.
REQ-033 SHALL pass this scenario: out_ready=0 for a whole frame of N=4, K=3, FIFO_DEPTH=4.
- stall_o rises after the 3rd write.
- If en continues, the 4th write fills the FIFO and no overflow occurs.
- A 5th-frame write sets overflow.
REQ-034 SHALL pass this scenario: full FIFO, out_ready=1 in the same cycle as a valid write.
- The oldest entry pops and the new one is stored.
- Occupancy stays 4 and overflow stays 0.
REQ-035 SHALL pass this scenario: rst low after 9 en pulses, then a fresh 16-pixel frame.
- All outputs and flags read 0 during reset.
- The next frame yields exactly 4 results in correct order.
REQ-036 SHALL pass this scenario: two back-to-back frames with gaps in en.
- 8 results total.
- frame_done pulses twice.
- Counters wrap correctly.
